// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a single memory port between an instruction
// fetch unit (read only) and an execution unit (read and write).
//
// Build option: define MEM_PORT_ARB_EXU_PRIO_EN to give EXU fixed priority on
// every tie. Otherwise, ties alternate round-robin and IFU wins the first tie
// after reset.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ifu_rd_req / ifu_rd_addr         fetch read request, held until ifu_gnt
//   ifu_gnt, ifu_rd_vld, ifu_rd_data fetch grant pulse, read-valid pulse, data
//   exu_rd_req, exu_wr_req           exec read / write requests, held until exu_gnt
//   exu_addr, exu_wr_data            exec address and write data
//   exu_gnt, exu_rd_vld, exu_rd_data exec grant pulse, read-valid pulse, data
//   mem_rd_req, mem_wr_req           one-cycle memory command strobes
//   mem_addr, mem_wr_data            memory command address / write data
//   mem_rd_data                      memory read data, one cycle after mem_rd_req
//   busy                             high whenever the FSM is not in IDLE
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_rd_req,
  input  logic [ADDR_W-1:0] ifu_rd_addr,
  output logic              ifu_gnt,
  output logic              ifu_rd_vld,
  output logic [DATA_W-1:0] ifu_rd_data,
  input  logic              exu_rd_req,
  input  logic              exu_wr_req,
  input  logic [ADDR_W-1:0] exu_addr,
  input  logic [DATA_W-1:0] exu_wr_data,
  output logic              exu_gnt,
  output logic              exu_rd_vld,
  output logic [DATA_W-1:0] exu_rd_data,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_d;

  // Owner of the transaction in flight (1 = EXU). In the round-robin build it
  // also records the last owner for tie-breaking.
  logic owner_exu, owner_exu_d;
  logic op_wr, op_wr_d;

  logic              ifu_gnt_d, exu_gnt_d;
  logic              ifu_rd_vld_d, exu_rd_vld_d;
  logic              mem_rd_req_d, mem_wr_req_d;
  logic              busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_d;
  logic [DATA_W-1:0] ifu_rd_data_d, exu_rd_data_d;

  logic ifu_pend, exu_pend, pick_exu;

  // Arbitration between pending requesters
  always_comb begin
    ifu_pend = ifu_rd_req;
    exu_pend = exu_rd_req | exu_wr_req;
`ifdef MEM_PORT_ARB_EXU_PRIO_EN
    pick_exu = exu_pend;
`else
    // On a tie the requester that did not own the last transaction wins.
    pick_exu = exu_pend & (~ifu_pend | ~owner_exu);
`endif
  end

  // Next-state and next-output logic; outputs are registered so every value
  // here is what the port shows during the state being entered.
  always_comb begin
    state_d       = state;
    owner_exu_d   = owner_exu;
    op_wr_d       = op_wr;
    ifu_gnt_d     = 1'b0;
    exu_gnt_d     = 1'b0;
    ifu_rd_vld_d  = 1'b0;
    exu_rd_vld_d  = 1'b0;
    mem_rd_req_d  = 1'b0;
    mem_wr_req_d  = 1'b0;
    busy_d        = 1'b1;
    mem_addr_d    = mem_addr;
    mem_wr_data_d = mem_wr_data;
    ifu_rd_data_d = ifu_rd_data;
    exu_rd_data_d = exu_rd_data;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (ifu_pend || exu_pend) begin
          state_d     = ISSUE;
          busy_d      = 1'b1;
          owner_exu_d = pick_exu;
          if (pick_exu) begin
            // A simultaneous EXU write goes first; the read stays pending.
            op_wr_d      = exu_wr_req;
            exu_gnt_d    = 1'b1;
            mem_addr_d   = exu_addr;
            mem_wr_req_d = exu_wr_req;
            mem_rd_req_d = ~exu_wr_req;
            if (exu_wr_req) begin
              mem_wr_data_d = exu_wr_data;
            end
          end else begin
            op_wr_d      = 1'b0;
            ifu_gnt_d    = 1'b1;
            mem_addr_d   = ifu_rd_addr;
            mem_rd_req_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (op_wr) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        state_d = RESP;
        if (owner_exu) begin
          exu_rd_data_d = mem_rd_data;
          exu_rd_vld_d  = 1'b1;
        end else begin
          ifu_rd_data_d = mem_rd_data;
          ifu_rd_vld_d  = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner_exu   <= 1'b1;
      op_wr       <= 1'b0;
      ifu_gnt     <= 1'b0;
      exu_gnt     <= 1'b0;
      ifu_rd_vld  <= 1'b0;
      exu_rd_vld  <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      ifu_rd_data <= '0;
      exu_rd_data <= '0;
    end else begin
      state       <= state_d;
      owner_exu   <= owner_exu_d;
      op_wr       <= op_wr_d;
      ifu_gnt     <= ifu_gnt_d;
      exu_gnt     <= exu_gnt_d;
      ifu_rd_vld  <= ifu_rd_vld_d;
      exu_rd_vld  <= exu_rd_vld_d;
      mem_rd_req  <= mem_rd_req_d;
      mem_wr_req  <= mem_wr_req_d;
      busy        <= busy_d;
      mem_addr    <= mem_addr_d;
      mem_wr_data <= mem_wr_data_d;
      ifu_rd_data <= ifu_rd_data_d;
      exu_rd_data <= exu_rd_data_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
// against a transaction-level model of arbitration and a memory image.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 12;
`ifdef MEM_PORT_ARB_EXU_PRIO_EN
  localparam bit EXU_PRIO = 1'b1;
`else
  localparam bit EXU_PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ifu_rd_req;
  logic [AW-1:0] ifu_rd_addr;
  logic          ifu_gnt, ifu_rd_vld;
  logic [DW-1:0] ifu_rd_data;
  logic          exu_rd_req, exu_wr_req;
  logic [AW-1:0] exu_addr;
  logic [DW-1:0] exu_wr_data;
  logic          exu_gnt, exu_rd_vld;
  logic [DW-1:0] exu_rd_data;
  logic          mem_rd_req, mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          busy;

  // {ifu_gnt, exu_gnt, ifu_rd_vld, exu_rd_vld, mem_rd_req, mem_wr_req, busy}
  logic [6:0] ctl;
  assign ctl = {ifu_gnt, exu_gnt, ifu_rd_vld, exu_rd_vld, mem_rd_req, mem_wr_req, busy};

  // Memory image: the model's view of memory, also serving reads to the DUT.
  logic [DW-1:0] mem_img [0:(1<<AW)-1];

  int checks = 0;
  int passes = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_gnt(ifu_gnt), .ifu_rd_vld(ifu_rd_vld), .ifu_rd_data(ifu_rd_data),
    .exu_rd_req(exu_rd_req), .exu_wr_req(exu_wr_req),
    .exu_addr(exu_addr), .exu_wr_data(exu_wr_data),
    .exu_gnt(exu_gnt), .exu_rd_vld(exu_rd_vld), .exu_rd_data(exu_rd_data),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory returns read data the cycle after mem_rd_req.
  always @(posedge clk) begin
    if (mem_rd_req) mem_rd_data <= mem_img[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    ifu_rd_req  = 1'b0;
    exu_rd_req  = 1'b0;
    exu_wr_req  = 1'b0;
    ifu_rd_addr = '0;
    exu_addr    = '0;
    exu_wr_data = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ctl !== 7'b0) $display("FAIL reset ctl: got %b want 0000000", ctl); else passes++;
    checks++;
    if ({mem_addr, mem_wr_data, ifu_rd_data, exu_rd_data} !== 48'h0)
      $display("FAIL reset data: got %h %h %h %h want all 0", mem_addr, mem_wr_data, ifu_rd_data, exu_rd_data);
    else passes++;
  endtask

  task automatic test_ifu_read();
    mem_img[12'o0200] = 12'o7300;
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = 12'o0200;
    tick();
    checks++;
    if (ctl !== 7'b1000101) $display("FAIL ifu_read c1 ctl: got %b want 1000101", ctl); else passes++;
    checks++;
    if (mem_addr !== 12'o0200) $display("FAIL ifu_read addr: got %o want 0200", mem_addr); else passes++;
    ifu_rd_req = 1'b0;
    tick();
    checks++;
    if (ctl !== 7'b0000001) $display("FAIL ifu_read c2 ctl: got %b want 0000001", ctl); else passes++;
    tick();
    checks++;
    if (ctl !== 7'b0010001) $display("FAIL ifu_read c3 ctl: got %b want 0010001", ctl); else passes++;
    checks++;
    if (ifu_rd_data !== 12'o7300) $display("FAIL ifu_read data: got %o want 7300", ifu_rd_data); else passes++;
    tick();
    checks++;
    if (ctl !== 7'b0) $display("FAIL ifu_read c4 ctl: got %b want 0000000", ctl); else passes++;
    checks++;
    if (ifu_rd_data !== 12'o7300) $display("FAIL ifu_read hold: got %o want 7300", ifu_rd_data); else passes++;
  endtask

  task automatic test_exu_write();
    exu_wr_req  = 1'b1;
    exu_addr    = 12'o0050;
    exu_wr_data = 12'o1234;
    tick();
    checks++;
    if (ctl !== 7'b0100011) $display("FAIL exu_write c1 ctl: got %b want 0100011", ctl); else passes++;
    checks++;
    if ({mem_addr, mem_wr_data} !== {12'o0050, 12'o1234})
      $display("FAIL exu_write cmd: got %o %o want 0050 1234", mem_addr, mem_wr_data);
    else passes++;
    exu_wr_req = 1'b0;
    mem_img[12'o0050] = 12'o1234;
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if (ctl !== 7'b0) $display("FAIL exu_write c%0d ctl: got %b want 0000000", c, ctl); else passes++;
    end
  endtask

  task automatic test_exu_both();
    exu_rd_req  = 1'b1;
    exu_wr_req  = 1'b1;
    exu_addr    = 12'h123;
    exu_wr_data = 12'h5a5;
    tick();
    checks++;
    if (ctl !== 7'b0100011) $display("FAIL exu_both write ctl: got %b want 0100011", ctl); else passes++;
    exu_wr_req = 1'b0;
    mem_img[12'h123] = 12'h5a5;
    tick();
    checks++;
    if (ctl !== 7'b0) $display("FAIL exu_both gap ctl: got %b want 0000000", ctl); else passes++;
    tick();
    checks++;
    if (ctl !== 7'b0100101) $display("FAIL exu_both read ctl: got %b want 0100101", ctl); else passes++;
    exu_rd_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({ctl, exu_rd_data} !== {7'b0001001, 12'h5a5})
      $display("FAIL exu_both resp: got %b %h want 0001001 5a5", ctl, exu_rd_data);
    else passes++;
    tick();
  endtask

  task automatic test_late_request();
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = 12'h0a7;
    tick();
    ifu_rd_req = 1'b0;
    tick();
    // EXU write arrives while the IFU read is in flight.
    exu_wr_req  = 1'b1;
    exu_addr    = 12'h0a8;
    exu_wr_data = 12'h3c3;
    tick();
    checks++;
    if ({ctl, ifu_rd_data} !== {7'b0010001, mem_img[12'h0a7]})
      $display("FAIL late c3: got %b %h want 0010001 %h", ctl, ifu_rd_data, mem_img[12'h0a7]);
    else passes++;
    tick();
    checks++;
    if (ctl !== 7'b0) $display("FAIL late c4 ctl: got %b want 0000000", ctl); else passes++;
    tick();
    checks++;
    if (ctl !== 7'b0100011) $display("FAIL late c5 ctl: got %b want 0100011", ctl); else passes++;
    exu_wr_req = 1'b0;
    mem_img[12'h0a8] = 12'h3c3;
    tick();
  endtask

  task automatic test_tie();
    logic exp_exu;
    do_reset();
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = 12'h011;
    exu_rd_req  = 1'b1;
    exu_addr    = 12'h022;
    for (int g = 0; g < 4; g++) begin
      exp_exu = EXU_PRIO ? 1'b1 : ((g % 2) == 1);
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (c == 1) begin
          checks++;
          if ({ifu_gnt, exu_gnt} !== {~exp_exu, exp_exu})
            $display("FAIL tie grant %0d: got ifu=%b exu=%b want ifu=%b exu=%b", g, ifu_gnt, exu_gnt, ~exp_exu, exp_exu);
          else passes++;
        end else begin
          checks++;
          if ({ifu_gnt, exu_gnt} !== 2'b00)
            $display("FAIL tie grant %0d cycle %0d: got %b%b want 00", g, c, ifu_gnt, exu_gnt);
          else passes++;
        end
      end
    end
    ifu_rd_req = 1'b0;
    exu_rd_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_wait();
    logic exp_exu;
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = 12'h040;
    tick();
    ifu_rd_req = 1'b0;
    tick();
    checks++;
    if (ctl !== 7'b0000001) $display("FAIL rst_wait pre ctl: got %b want 0000001", ctl); else passes++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({ctl, mem_addr, mem_wr_data, ifu_rd_data, exu_rd_data} !== 55'h0)
      $display("FAIL rst_wait outputs: got %b %h %h %h %h want all 0", ctl, mem_addr, mem_wr_data, ifu_rd_data, exu_rd_data);
    else passes++;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ctl !== 7'b0) $display("FAIL rst_wait idle %0d: got %b want 0000000", c, ctl); else passes++;
    end
    exp_exu = EXU_PRIO;
    ifu_rd_req = 1'b1;
    exu_rd_req = 1'b1;
    exu_addr   = 12'h041;
    tick();
    checks++;
    if ({ifu_gnt, exu_gnt} !== {~exp_exu, exp_exu})
      $display("FAIL rst_wait tie: got ifu=%b exu=%b want ifu=%b exu=%b", ifu_gnt, exu_gnt, ~exp_exu, exp_exu);
    else passes++;
    ifu_rd_req = 1'b0;
    exu_rd_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_random();
    logic last_exu, win_exu, op_wr, ifu_p, exu_p;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_data;
    do_reset();
    last_exu = 1'b1;
    for (int n = 0; n < 40; n++) begin
      // New requests only from requesters with nothing outstanding.
      if (!ifu_rd_req && ($urandom_range(0, 1) == 1)) begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = AW'($urandom_range(0, 15));
      end
      if (!exu_rd_req && !exu_wr_req && ($urandom_range(0, 1) == 1)) begin
        case ($urandom_range(0, 2))
          0:       exu_rd_req = 1'b1;
          1:       exu_wr_req = 1'b1;
          default: begin exu_rd_req = 1'b1; exu_wr_req = 1'b1; end
        endcase
        exu_addr    = AW'($urandom_range(0, 15));
        exu_wr_data = DW'($urandom);
      end
      if (!ifu_rd_req && !exu_rd_req && !exu_wr_req) begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = AW'($urandom_range(0, 15));
      end

      // Model: lone requester wins; ties go by priority or alternation.
      ifu_p = ifu_rd_req;
      exu_p = exu_rd_req || exu_wr_req;
      if (ifu_p && exu_p) win_exu = EXU_PRIO ? 1'b1 : !last_exu;
      else                win_exu = exu_p;
      op_wr = win_exu && exu_wr_req;
      a     = win_exu ? exu_addr : ifu_rd_addr;

      tick();
      checks++;
      if (ctl !== {~win_exu, win_exu, 2'b00, ~op_wr, op_wr, 1'b1})
        $display("FAIL rand %0d grant ctl: got %b want %b", n, ctl, {~win_exu, win_exu, 2'b00, ~op_wr, op_wr, 1'b1});
      else passes++;
      checks++;
      if (mem_addr !== a) $display("FAIL rand %0d addr: got %h want %h", n, mem_addr, a); else passes++;

      last_exu = win_exu;
      if (op_wr) begin
        checks++;
        if (mem_wr_data !== exu_wr_data)
          $display("FAIL rand %0d wdata: got %h want %h", n, mem_wr_data, exu_wr_data);
        else passes++;
        mem_img[a] = exu_wr_data;
        exu_wr_req = 1'b0;
        tick();
        checks++;
        if (ctl !== 7'b0) $display("FAIL rand %0d wr end ctl: got %b want 0000000", n, ctl); else passes++;
      end else begin
        exp_data = mem_img[a];
        if (win_exu) exu_rd_req = 1'b0; else ifu_rd_req = 1'b0;
        tick();
        checks++;
        if (ctl !== 7'b0000001) $display("FAIL rand %0d wait ctl: got %b want 0000001", n, ctl); else passes++;
        tick();
        checks++;
        if (ctl !== {4'b0000 | {2'b00, ~win_exu, win_exu}, 3'b001})
          $display("FAIL rand %0d resp ctl: got %b want %b", n, ctl, {2'b00, ~win_exu, win_exu, 3'b001});
        else passes++;
        checks++;
        if ((win_exu ? exu_rd_data : ifu_rd_data) !== exp_data)
          $display("FAIL rand %0d rdata: got %h want %h", n, win_exu ? exu_rd_data : ifu_rd_data, exp_data);
        else passes++;
        tick();
        checks++;
        if (ctl !== 7'b0) $display("FAIL rand %0d rd end ctl: got %b want 0000000", n, ctl); else passes++;
      end
    end
    ifu_rd_req = 1'b0;
    exu_rd_req = 1'b0;
    exu_wr_req = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_img[i] = DW'($urandom);
    test_reset();
    test_ifu_read();
    test_exu_write();
    test_exu_both();
    test_late_request();
    test_tie();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
